// File: rtl/mem_lsu_pkg.sv
// Shared types for the memory stage: memory-op codes, FSM states and op classifiers.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_load(mem_op_t op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic is_store(mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Pipeline-side and data-bus signals of the memory stage.
// slave = the memory stage itself, master = its environment (pipeline + memory).
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  mem_op_t     mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        stall_req_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;
  logic        misalign_o;
  logic        bus_err_o;

  modport slave (
    input  reg_waddr_i, reg_we_i, reg_wdata_i, mem_op_i, mem_addr_i, mem_sdata_i,
    input  dbus_ack_i, dbus_rdata_i,
    output reg_waddr_o, reg_we_o, reg_wdata_o, stall_req_o,
    output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
    output misalign_o, bus_err_o
  );

  modport master (
    output reg_waddr_i, reg_we_i, reg_wdata_i, mem_op_i, mem_addr_i, mem_sdata_i,
    output dbus_ack_i, dbus_rdata_i,
    input  reg_waddr_o, reg_we_o, reg_wdata_o, stall_req_o,
    input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
    input  misalign_o, bus_err_o
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: store byte-enable/data steering, load extract/extend,
// and the alignment check on the op currently offered by exe_mem.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  input  mem_op_t     chk_op,
  input  logic [1:0]  chk_addr_lo,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be    = 4'b0000;
    wdata = 32'd0;
    ldata = 32'd0;
    case (op)
      MEM_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{sdata[7:0]}};
      end
      MEM_SH: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sdata[15:0]}};
      end
      MEM_SW: begin
        be    = 4'b1111;
        wdata = sdata;
      end
      MEM_LB:  begin be = 4'b1111; ldata = {{24{byte_v[7]}}, byte_v}; end
      MEM_LBU: begin be = 4'b1111; ldata = {24'd0, byte_v}; end
      MEM_LH:  begin be = 4'b1111; ldata = {{16{half_v[15]}}, half_v}; end
      MEM_LHU: begin be = 4'b1111; ldata = {16'd0, half_v}; end
      MEM_LW:  begin be = 4'b1111; ldata = rdata; end
      default: ;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    case (chk_op)
      MEM_LH, MEM_LHU, MEM_SH: misalign = chk_addr_lo[0];
      MEM_LW, MEM_SW:          misalign = |chk_addr_lo;
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// Memory stage: zero-latency pass-through for ALU ops, stalling req/ack bus
// transaction for loads/stores with timeout abort.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic      clk_i,
  input logic      rst_i,
  mem_lsu_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state_reg, state_next;
  mem_op_t          op_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      sdata_reg;
  logic [4:0]       waddr_reg;
  logic [31:0]      result_reg;
  logic             wb_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             start;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata;
  logic [31:0]      lane_ldata;
  logic             in_misalign;

  mem_lsu_align u_align (
    .op          (op_reg),
    .addr_lo     (addr_reg[1:0]),
    .sdata       (sdata_reg),
    .rdata       (bus.dbus_rdata_i),
    .chk_op      (bus.mem_op_i),
    .chk_addr_lo (bus.mem_addr_i[1:0]),
    .be          (lane_be),
    .wdata       (lane_wdata),
    .ldata       (lane_ldata),
    .misalign    (in_misalign)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= ST_IDLE;
      op_reg     <= MEM_NONE;
      addr_reg   <= 32'd0;
      sdata_reg  <= 32'd0;
      waddr_reg  <= 5'd0;
      result_reg <= 32'd0;
      wb_reg     <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        op_reg    <= bus.mem_op_i;
        addr_reg  <= bus.mem_addr_i;
        sdata_reg <= bus.mem_sdata_i;
        waddr_reg <= bus.reg_waddr_i;
        wb_reg    <= 1'b0;
        cnt_reg   <= '0;
      end else if (state_reg == ST_REQ) begin
        if (bus.dbus_ack_i) begin
          if (is_load(op_reg)) begin
            result_reg <= lane_ldata;
            wb_reg     <= 1'b1;
          end
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  // Reset gates every output combinationally so an in-flight request drops at once.
  always_comb begin
    state_next       = state_reg;
    start            = 1'b0;
    bus.reg_waddr_o  = 5'd0;
    bus.reg_we_o     = 1'b0;
    bus.reg_wdata_o  = 32'd0;
    bus.stall_req_o  = 1'b0;
    bus.dbus_req_o   = 1'b0;
    bus.dbus_we_o    = 1'b0;
    bus.dbus_addr_o  = 32'd0;
    bus.dbus_be_o    = 4'b0000;
    bus.dbus_wdata_o = 32'd0;
    bus.misalign_o   = 1'b0;
    bus.bus_err_o    = 1'b0;
    if (!rst_i) begin
      case (state_reg)
        ST_IDLE: begin
          bus.reg_waddr_o = bus.reg_waddr_i;
          bus.reg_wdata_o = bus.reg_wdata_i;
          if (bus.mem_op_i == MEM_NONE) begin
            bus.reg_we_o = bus.reg_we_i;
          end else if (in_misalign) begin
            bus.misalign_o = 1'b1;
          end else begin
            bus.stall_req_o = 1'b1;
            start           = 1'b1;
            state_next      = ST_REQ;
          end
        end
        ST_REQ: begin
          bus.stall_req_o  = 1'b1;
          bus.dbus_req_o   = 1'b1;
          bus.dbus_we_o    = is_store(op_reg);
          bus.dbus_addr_o  = {addr_reg[31:2], 2'b00};
          bus.dbus_be_o    = lane_be;
          bus.dbus_wdata_o = lane_wdata;
          bus.reg_waddr_o  = waddr_reg;
          if (bus.dbus_ack_i) begin
            state_next = ST_DONE;
          end else if (TIMEOUT != 0 && cnt_reg == CNT_LAST) begin
            bus.bus_err_o = 1'b1;
            state_next    = ST_DONE;
          end
        end
        ST_DONE: begin
          // exe_mem still holds the finished op here, so its inputs are not looked at.
          bus.reg_waddr_o = waddr_reg;
          bus.reg_wdata_o = result_reg;
          bus.reg_we_o    = wb_reg;
          state_next      = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: stimulus pushes expected events, a negedge
// monitor pops and compares bus requests, stall runs, writebacks and pulses.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int K_WB    = 0;
  localparam int K_BUS   = 1;
  localparam int K_ERR   = 2;
  localparam int K_MIS   = 3;
  localparam int K_STALL = 4;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  be;
    logic        we;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prev_req = 1'b0;
  int   stall_len = 0;

  mem_lsu_if bus_if ();

  mem_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  function automatic string kname(int k);
    case (k)
      K_WB:    return "WB";
      K_BUS:   return "BUS";
      K_ERR:   return "BUSERR";
      K_MIS:   return "MISALIGN";
      default: return "STALL";
    endcase
  endfunction

  function automatic ev_t mk(int kind, logic [31:0] a, logic [31:0] b, logic [3:0] be, logic we);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.be = be; e.we = we;
    return e;
  endfunction

  task automatic push(int kind, logic [31:0] a, logic [31:0] b, logic [3:0] be, logic we);
    exp_q.push_back(mk(kind, a, b, be, we));
  endtask

  task automatic observe(ev_t g);
    ev_t e;
    bit  ok;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got a=%h b=%h be=%b we=%b, required no event",
               kname(g.kind), g.a, g.b, g.be, g.we);
      return;
    end
    e  = exp_q.pop_front();
    ok = (e.kind == g.kind);
    if (ok) begin
      case (g.kind)
        K_WB:    ok = (g.a == e.a) && (g.b == e.b);
        K_BUS:   ok = (g.we == e.we) && (g.a == e.a) && (g.be == e.be) && (!e.we || g.b == e.b);
        K_STALL: ok = (g.a == e.a);
        default: ok = 1'b1;
      endcase
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s a=%h b=%h be=%b we=%b, required %s a=%h b=%h be=%b we=%b",
               kname(e.kind), kname(g.kind), g.a, g.b, g.be, g.we,
               kname(e.kind), e.a, e.b, e.be, e.we);
    end else begin
      $display("ok   %s a=%h b=%h be=%b we=%b", kname(g.kind), g.a, g.b, g.be, g.we);
    end
  endtask

  task automatic check_eq(string name, logic [31:0] got, logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  always @(negedge clk) begin
    if (bus_if.dbus_req_o && !prev_req)
      observe(mk(K_BUS, bus_if.dbus_addr_o, bus_if.dbus_wdata_o, bus_if.dbus_be_o, bus_if.dbus_we_o));
    if (bus_if.bus_err_o)
      observe(mk(K_ERR, 32'd0, 32'd0, 4'd0, 1'b0));
    if (bus_if.stall_req_o) begin
      stall_len++;
    end else if (stall_len != 0) begin
      observe(mk(K_STALL, 32'(stall_len), 32'd0, 4'd0, 1'b0));
      stall_len = 0;
    end
    if (bus_if.misalign_o)
      observe(mk(K_MIS, 32'd0, 32'd0, 4'd0, 1'b0));
    if (bus_if.reg_we_o)
      observe(mk(K_WB, {27'd0, bus_if.reg_waddr_o}, bus_if.reg_wdata_o, 4'd0, 1'b0));
    prev_req = bus_if.dbus_req_o;
  end

  task automatic set_idle();
    bus_if.mem_op_i     = MEM_NONE;
    bus_if.reg_we_i     = 1'b0;
    bus_if.reg_waddr_i  = 5'd0;
    bus_if.reg_wdata_i  = 32'd0;
    bus_if.mem_addr_i   = 32'd0;
    bus_if.mem_sdata_i  = 32'd0;
    bus_if.dbus_ack_i   = 1'b0;
    bus_if.dbus_rdata_i = 32'd0;
  endtask

  // Holds the op until a cycle ends with stall low, acking after ack_wait REQ cycles.
  task automatic run_op(mem_op_t op, logic [31:0] addr, logic [31:0] sdata, logic [4:0] waddr,
                        logic we, logic [31:0] wdata, int ack_wait, logic [31:0] rdata);
    int req_cycles = 0;
    bit done = 1'b0;
    bus_if.mem_op_i    = op;
    bus_if.mem_addr_i  = addr;
    bus_if.mem_sdata_i = sdata;
    bus_if.reg_waddr_i = waddr;
    bus_if.reg_we_i    = we;
    bus_if.reg_wdata_i = wdata;
    for (int c = 0; c < 64 && !done; c++) begin
      if (bus_if.dbus_req_o) begin
        bus_if.dbus_ack_i   = (req_cycles == ack_wait);
        bus_if.dbus_rdata_i = rdata;
        req_cycles++;
      end else begin
        bus_if.dbus_ack_i = 1'b0;
      end
      @(negedge clk);
      if (!bus_if.stall_req_o) done = 1'b1;
      @(posedge clk);
      #1;
      bus_if.dbus_ack_i = 1'b0;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL op_complete: op %s still stalling after 64 cycles, required stall release", op.name());
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    rst                 = 1'b1;
    bus_if.reg_we_i     = 1'b1;
    bus_if.reg_waddr_i  = 5'd7;
    bus_if.reg_wdata_i  = 32'hFFFF_FFFF;
    bus_if.dbus_ack_i   = 1'b1;
    bus_if.dbus_rdata_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_reg_we",    {31'd0, bus_if.reg_we_o},    32'd0);
      check_eq("rst_reg_waddr", {27'd0, bus_if.reg_waddr_o}, 32'd0);
      check_eq("rst_reg_wdata", bus_if.reg_wdata_o,          32'd0);
      check_eq("rst_stall",     {31'd0, bus_if.stall_req_o}, 32'd0);
      check_eq("rst_dbus_req",  {31'd0, bus_if.dbus_req_o},  32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_idle();

    push(K_WB, 32'd5, 32'h1234, 4'd0, 1'b0);
    run_op(MEM_NONE, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 32'h0);

    push(K_BUS, 32'h100, 32'h0, 4'b1111, 1'b0);
    push(K_STALL, 32'd2, 32'h0, 4'd0, 1'b0);
    push(K_WB, 32'd3, 32'hFFFF_FF80, 4'd0, 1'b0);
    run_op(MEM_LB, 32'h103, 32'h0, 5'd3, 1'b1, 32'hAAAA, 0, 32'h80FF_FFFF);

    push(K_BUS, 32'h100, 32'h0, 4'b1111, 1'b0);
    push(K_STALL, 32'd2, 32'h0, 4'd0, 1'b0);
    push(K_WB, 32'd3, 32'h0000_0080, 4'd0, 1'b0);
    run_op(MEM_LBU, 32'h103, 32'h0, 5'd3, 1'b1, 32'hAAAA, 0, 32'h80FF_FFFF);

    push(K_BUS, 32'h100, 32'h0, 4'b1111, 1'b0);
    push(K_STALL, 32'd3, 32'h0, 4'd0, 1'b0);
    push(K_WB, 32'd4, 32'hFFFF_80FF, 4'd0, 1'b0);
    run_op(MEM_LH, 32'h102, 32'h0, 5'd4, 1'b1, 32'h0, 1, 32'h80FF_1234);

    push(K_BUS, 32'h100, 32'h0, 4'b1111, 1'b0);
    push(K_STALL, 32'd2, 32'h0, 4'd0, 1'b0);
    push(K_WB, 32'd4, 32'h0000_80FF, 4'd0, 1'b0);
    run_op(MEM_LHU, 32'h102, 32'h0, 5'd4, 1'b1, 32'h0, 0, 32'h80FF_1234);

    push(K_BUS, 32'h200, 32'h1234_1234, 4'b1100, 1'b1);
    push(K_STALL, 32'd5, 32'h0, 4'd0, 1'b0);
    run_op(MEM_SH, 32'h202, 32'hABCD_1234, 5'd2, 1'b0, 32'h0, 3, 32'h0);

    push(K_BUS, 32'h300, 32'h5A5A_5A5A, 4'b0010, 1'b1);
    push(K_STALL, 32'd2, 32'h0, 4'd0, 1'b0);
    run_op(MEM_SB, 32'h301, 32'h1122_335A, 5'd2, 1'b0, 32'h0, 0, 32'h0);

    push(K_BUS, 32'h40C, 32'hCAFE_F00D, 4'b1111, 1'b1);
    push(K_STALL, 32'd2, 32'h0, 4'd0, 1'b0);
    run_op(MEM_SW, 32'h40C, 32'hCAFE_F00D, 5'd8, 1'b1, 32'h5555, 0, 32'h0);

    push(K_MIS, 32'h0, 32'h0, 4'd0, 1'b0);
    run_op(MEM_LW, 32'h101, 32'h0, 5'd6, 1'b1, 32'h77, 0, 32'h0);

    push(K_MIS, 32'h0, 32'h0, 4'd0, 1'b0);
    run_op(MEM_SH, 32'h203, 32'h1111, 5'd0, 1'b0, 32'h0, 0, 32'h0);

    // Ack with no request in flight must produce no event.
    bus_if.dbus_ack_i   = 1'b1;
    bus_if.dbus_rdata_i = 32'h1357_9BDF;
    repeat (3) @(posedge clk);
    #1;
    bus_if.dbus_ack_i = 1'b0;

    push(K_BUS, 32'h500, 32'h0, 4'b1111, 1'b0);
    push(K_ERR, 32'h0, 32'h0, 4'd0, 1'b0);
    push(K_STALL, 32'd5, 32'h0, 4'd0, 1'b0);
    run_op(MEM_LW, 32'h500, 32'h0, 5'd10, 1'b1, 32'h0, -1, 32'h0);

    push(K_BUS, 32'h300, 32'h0, 4'b1111, 1'b0);
    push(K_STALL, 32'd2, 32'h0, 4'd0, 1'b0);
    bus_if.mem_op_i    = MEM_LW;
    bus_if.mem_addr_i  = 32'h300;
    bus_if.reg_waddr_i = 5'd6;
    bus_if.reg_we_i    = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rstreq_dbus_req",  {31'd0, bus_if.dbus_req_o},  32'd0);
    check_eq("rstreq_stall",     {31'd0, bus_if.stall_req_o}, 32'd0);
    check_eq("rstreq_dbus_addr", bus_if.dbus_addr_o,          32'd0);
    check_eq("rstreq_dbus_be",   {28'd0, bus_if.dbus_be_o},   32'd0);
    check_eq("rstreq_reg_we",    {31'd0, bus_if.reg_we_o},    32'd0);
    set_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;

    push(K_BUS, 32'h104, 32'h0, 4'b1111, 1'b0);
    push(K_STALL, 32'd2, 32'h0, 4'd0, 1'b0);
    push(K_WB, 32'd9, 32'hDEAD_BEEF, 4'd0, 1'b0);
    run_op(MEM_LW, 32'h104, 32'h0, 5'd9, 1'b1, 32'h0, 0, 32'hDEAD_BEEF);

    repeat (3) @(posedge clk);
    #1;
    check_eq("pending_expected", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
